// File: rtl/icache_dm_ro.sv
// Direct-mapped read-only instruction cache with single-line refill and saturating miss counter.
// Hits complete combinationally; a miss stalls until the 128-bit line returns from memory.
module icache_dm_ro #(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             proc_read,
  input  logic [29:0]      proc_addr,
  output logic [31:0]      proc_rdata,
  output logic             proc_stall,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 28 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [127:0]       r_data [LINES];
  logic               r_memRead;
  logic [27:0]        r_memAddr;
  logic [CNT_W-1:0]   r_missCount;

  logic [1:0]         w_offset;
  logic [IDX-1:0]     w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_fill;
  logic [IDX-1:0]     w_fillIdx;
  logic [TAG_W-1:0]   w_fillTag;
  logic [127:0]       w_lineData;

  assign w_offset   = proc_addr[1:0];
  assign w_index    = proc_addr[IDX+1:2];
  assign w_tag      = proc_addr[29:IDX+2];
  assign w_hit      = proc_read & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_fill     = (r_state == FETCH) & mem_ready;
  assign w_fillIdx  = r_memAddr[IDX-1:0];
  assign w_fillTag  = r_memAddr[27:IDX];
  assign w_lineData = r_data[w_index];

  assign proc_rdata = w_lineData[{w_offset, 5'd0} +: 32];
  assign proc_stall = (r_state == FETCH) | (proc_read & ~w_hit);
  assign mem_read   = r_memRead;
  assign mem_addr   = r_memAddr;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;
  assign miss_count = r_missCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_memRead   <= 1'b0;
      r_memAddr   <= '0;
      r_missCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (proc_read && !w_hit) begin
            r_state   <= FETCH;
            r_memRead <= 1'b1;
            r_memAddr <= proc_addr[29:2];
            if (r_missCount != '1) begin
              r_missCount <= r_missCount + 1'b1;
            end
          end
        end
        FETCH: begin
          // Refill target comes from the latched line address, not the live proc_addr.
          if (mem_ready) begin
            r_valid[w_fillIdx] <= 1'b1;
            r_memRead          <= 1'b0;
            r_state            <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays are left unreset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fillIdx]  <= w_fillTag;
      r_data[w_fillIdx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_dm_ro.sv
// Directed-vector bench for icache_dm_ro: table of fetches, reset-during-refill,
// counter saturation on a narrow-counter instance, and a random stream against a small model.
module tb_icache_dm_ro;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  miss_count;

  logic [31:0]  satRdata;
  logic         satStall;
  logic         satMemRead;
  logic         satMemWrite;
  logic [27:0]  satMemAddr;
  logic [127:0] satMemWdata;
  logic [3:0]   satCount;

  int total = 0;
  int bad   = 0;

  icache_dm_ro #(.LINES(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_addr(proc_addr),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .miss_count(miss_count)
  );

  // Same stimulus, 4-bit counter, so saturation shows up without thousands of misses.
  icache_dm_ro #(.LINES(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_addr(proc_addr),
    .proc_rdata(satRdata), .proc_stall(satStall), .mem_read(satMemRead),
    .mem_write(satMemWrite), .mem_addr(satMemAddr), .mem_wdata(satMemWdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .miss_count(satCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [29:0] a);
    memWord = {a, 2'b01} ^ 32'hC3A5_0F1E ^ (32'(a) * 32'h0101_0107);
  endfunction

  function automatic logic [127:0] memLine(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = memWord({la, 2'(k)});
    memLine = l;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Constant outputs and address stability while a refill is outstanding.
  logic        prevRead = 1'b0;
  logic [27:0] prevAddr = '0;
  always @(negedge clk) begin
    #2;
    checkOutput("memWrite0", 32'(mem_write), 32'd0);
    checkOutput("memWdata0", 32'(mem_wdata != '0), 32'd0);
    if (prevRead && mem_read) checkOutput("memAddrStable", 32'(mem_addr), 32'(prevAddr));
    prevRead = mem_read;
    prevAddr = mem_addr;
  end

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; proc_read = 1'b0; proc_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstStall", 32'(proc_stall), 32'd0);
    checkOutput("rstMemRead", 32'(mem_read), 32'd0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
    checkOutput("rstCount", 32'(miss_count), 32'd0);
    checkOutput("rstSatCount", 32'(satCount), 32'd0);
  endtask

  // One fetch; lat = cycles of mem_read before mem_ready pulses.
  task automatic applyStimulus(input logic [29:0] addr, input int lat, input bit expMiss,
                               input int expCount, input string name);
    bit gotMiss;
    int satExp;
    @(negedge clk);
    proc_read = 1'b1; proc_addr = addr; mem_ready = 1'b0;
    #1;
    gotMiss = proc_stall;
    checkOutput({name, ".miss"}, 32'(gotMiss), 32'(expMiss));
    if (gotMiss) begin
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        if (c == lat) begin
          mem_ready = 1'b1;
          mem_rdata = memLine(addr[29:2]);
        end
        #1;
        checkOutput({name, ".memRead"}, 32'(mem_read), 32'd1);
        checkOutput({name, ".memAddr"}, 32'(mem_addr), 32'(addr[29:2]));
        checkOutput({name, ".stallFetch"}, 32'(proc_stall), 32'd1);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = ~memLine(addr[29:2]);
      #1;
      checkOutput({name, ".stallDone"}, 32'(proc_stall), 32'd0);
    end
    checkOutput({name, ".memReadIdle"}, 32'(mem_read), 32'd0);
    checkOutput({name, ".rdata"}, proc_rdata, memWord(addr));
    checkOutput({name, ".count"}, 32'(miss_count), 32'(expCount));
    satExp = (expCount > 15) ? 15 : expCount;
    checkOutput({name, ".satCount"}, 32'(satCount), 32'(satExp));
  endtask

  typedef struct {
    logic [29:0] addr;
    int          lat;
    bit          expMiss;
    int          expCount;
    string       name;
  } vec_t;

  vec_t vecs [9];

  bit          mValid [8];
  logic [24:0] mTag [8];
  int          misses;

  initial begin
    rst_n = 1'b1; proc_read = 1'b0; proc_addr = '0; mem_ready = 1'b0; mem_rdata = '0;

    vecs[0] = '{30'h05, 3, 1'b1, 1, "cold"};
    vecs[1] = '{30'h04, 0, 1'b0, 1, "spatial4"};
    vecs[2] = '{30'h06, 0, 1'b0, 1, "spatial6"};
    vecs[3] = '{30'h07, 0, 1'b0, 1, "spatial7"};
    vecs[4] = '{30'h00, 2, 1'b1, 2, "conflictA"};
    vecs[5] = '{30'h20, 1, 1'b1, 3, "conflictB"};
    vecs[6] = '{30'h00, 4, 1'b1, 4, "conflictA2"};
    vecs[7] = '{30'h05, 0, 1'b0, 4, "line1Kept"};
    vecs[8] = '{30'h21, 2, 1'b1, 5, "conflictB2"};

    doReset();
    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i].addr, vecs[i].lat, vecs[i].expMiss, vecs[i].expCount, vecs[i].name);

    // Reset while the refill is outstanding, then a stray mem_ready in IDLE.
    doReset();
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h40;
    @(negedge clk);
    #1;
    checkOutput("midFetch.memRead", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midFetch.asyncDrop", 32'(mem_read), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; proc_read = 1'b0;
    mem_ready = 1'b1; mem_rdata = memLine(28'h10);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checkOutput("stray.memRead", 32'(mem_read), 32'd0);
    checkOutput("stray.count", 32'(miss_count), 32'd0);
    applyStimulus(30'h40, 2, 1'b1, 1, "refetch");

    // Twenty misses on index 0 with distinct tags.
    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(30'(i * 32), 1, 1'b1, i + 1, "sat");

    // Random stream over 256 words against a direct-mapped reference.
    doReset();
    misses = 0;
    for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic [29:0] a;
      bit          m;
      a = 30'($urandom_range(0, 255));
      m = !(mValid[a[4:2]] && (mTag[a[4:2]] == a[29:5]));
      if (m) begin
        mValid[a[4:2]] = 1'b1;
        mTag[a[4:2]]   = a[29:5];
        misses++;
      end
      applyStimulus(a, int'($urandom_range(1, 3)), m, misses, "rand");
    end

    proc_read = 1'b0;
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_dm_ro.md
Name: icache_dm_ro

Overview:
- Direct-mapped, read-only instruction cache placed between the RISC-V fetch stage and the slow instruction memory.
- Acts as the initiator (requester) of the 128-bit line protocol: mem_read, mem_write, mem_addr[31:4], mem_wdata, mem_rdata, mem_ready.
- Serves 32-bit word fetches. A hit returns data with zero added latency. A miss refills one 4-word line.
- Exposes a saturating miss counter for performance reporting.

Parameters:
- LINES, 8, number of cache lines; power of two, at least 2. IDX = log2(LINES).
- CNT_W, 16, width of the miss counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- proc_read  input  1  fetch request; held high until proc_stall is low
- proc_addr  input  30  word address; held stable while proc_stall is high
- proc_rdata  output  32  fetched word; valid when proc_read=1 and proc_stall=0
- proc_stall  output  1  high while the request cannot complete this cycle
- mem_read  output  1  line read request (registered)
- mem_write  output  1  constant 0
- mem_addr  output  28  line address, equal to proc_addr[29:2] latched at miss (registered)
- mem_wdata  output  128  constant 0
- mem_rdata  input  128  refill line; word k occupies bits [32k+31:32k]
- mem_ready  input  1  one-cycle pulse; mem_rdata is valid in that cycle
- miss_count  output  CNT_W  number of misses since reset, saturating

Behaviour:
- Address split: offset = proc_addr[1:0]; index = proc_addr[IDX+1:2]; tag = proc_addr[29:IDX+2].
- Storage per line: valid bit, tag, 128-bit data.
- hit = proc_read & valid[index] & (tag_mem[index] == tag). This is combinational.
- Reset (asynchronous): all valid bits cleared, state = IDLE, mem_read = 0, mem_addr = 0, miss_count = 0. Data and tag arrays are not reset.
- Outputs: proc_rdata is combinational from the data array and is don't-care when proc_stall=1. proc_stall is combinational.
- FSM, two states:
  - IDLE
    - proc_stall = proc_read & ~hit.
    - On proc_read & ~hit: go to FETCH next edge; set mem_read=1; latch mem_addr = proc_addr[29:2]; increment miss_count unless it is all-ones.
    - proc_read=0: no action.
    - mem_ready seen in IDLE is ignored.
  - FETCH
    - proc_stall = 1.
    - mem_read and mem_addr stay constant until mem_ready.
    - On the edge where mem_ready=1:
      - write mem_rdata into line mem_addr[IDX-1:0];
      - set the tag from mem_addr[27:IDX] and set valid;
      - mem_read = 0;
      - go to IDLE.
    - The next cycle is a hit, so the miss completes one cycle after mem_ready.
    - No timeout: FETCH waits for mem_ready indefinitely.
- Latency:
  - Hit: same cycle.
  - Miss: proc_stall is high from the request cycle through the mem_ready cycle inclusive. Stall cycles = (memory latency) + 1.
- mem_read is high for exactly one contiguous interval per miss and is never asserted in IDLE.
- Only one outstanding request at a time; back-to-back misses produce separate refills.
- Conflicting line: refill overwrites the existing line unconditionally. There are no dirty lines, so there is no writeback.
- proc_addr changing during FETCH violates protocol. The refill still completes for the latched address, and the hit check then uses the current proc_addr.
- Reset during FETCH: mem_read drops immediately (asynchronous). A mem_ready arriving later is ignored in IDLE, and the cache stays empty.
- Simultaneous events:
  - mem_ready coincides with a new address only after the stall releases; not applicable during the stall.
  - proc_read falling during FETCH: the refill still completes.

Test Plan:
- Cold miss: reset, proc_read=1, proc_addr=0x0000_0005, memory latency 3 → mem_read=1, mem_addr=0x000_0001 next cycle. Stall lasts until mem_ready plus 1. proc_rdata = line word 1. miss_count=1.
- Spatial hit: after the above, proc_addr=0x0000_0004, 0x6, 0x7 on consecutive cycles → proc_stall=0 every cycle, correct words returned, miss_count stays 1, mem_read stays 0.
- Conflict: LINES=8; fetch 0x0000_0000, then 0x0000_0020 (same index, different tag), then 0x0000_0000 → three refills and miss_count=3. Each mem_addr matches its address (0x000_0000, 0x000_0008, 0x000_0000).
- Reset mid-FETCH: assert rst_n=0 while mem_read=1 → mem_read=0 in the same cycle. A stray mem_ready after reset is ignored. A re-fetch of the same address misses again.
- Saturation: CNT_W=4; 20 distinct-tag misses → miss_count stops at 15.
- Random fetch stream of 2000 addresses in a 256-word space against a reference model → every returned word matches memory. mem_addr is stable for the entire time mem_read is high, and mem_write is always 0.
